// File: rtl/reconstrutor_diferenca.sv
// Bit-serial delta reconstructor: R <= R +/- D over 4 clocks using one adder/subtractor cell.
// Latency inicio->valido 4 cycles; pronto low during CALCULA/FIM, requests outside OCIOSO are dropped.
module reconstrutor_diferenca (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       carga,
    input  logic [3:0] A,
    input  logic       inicio,
    input  logic       sinal,
    input  logic [3:0] D,
    output logic       pronto,
    output logic [3:0] S,
    output logic       valido,
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t    r_estado;
    estado_t    w_prox;

    logic [1:0] r_cnt;
    logic       r_c;
    logic [3:0] r_dsh;
    logic       r_sinal_sh;
    logic [3:0] r_work;
    logic [3:0] r_R;
    logic       r_erro;

    logic       w_a;
    logic       w_b;
    logic       w_soma;
    logic       w_c_prox;
    logic       w_ultimo;
    logic [3:0] w_resultado;

    // Single full-adder/subtractor cell; carry and borrow share r_c.
    assign w_a         = r_R[r_cnt];
    assign w_b         = r_dsh[r_cnt];
    assign w_soma      = w_a ^ w_b ^ r_c;
    assign w_c_prox    = r_sinal_sh ? ((~w_a & w_b) | (~(w_a ^ w_b) & r_c))
                                    : ((w_a & w_b) | (w_a & r_c) | (w_b & r_c));
    assign w_ultimo    = (r_cnt == 2'd3);
    assign w_resultado = {w_soma, r_work[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        pronto = 1'b0;
        valido = 1'b0;
        case (r_estado)
            OCIOSO: begin
                pronto = 1'b1;
                if (inicio && !carga) begin
                    w_prox = CALCULA;
                end
            end
            CALCULA: begin
                if (w_ultimo) begin
                    w_prox = FIM;
                end
            end
            FIM: begin
                valido = 1'b1;
                w_prox = OCIOSO;
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    // R is only written on carga or after the last bit, so an abort never leaves a partial value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 2'd0;
            r_c        <= 1'b0;
            r_dsh      <= 4'd0;
            r_sinal_sh <= 1'b0;
            r_work     <= 4'd0;
            r_R        <= 4'd0;
            r_erro     <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (carga) begin
                        r_R    <= A;
                        r_erro <= 1'b0;
                    end else if (inicio) begin
                        r_dsh      <= D;
                        r_sinal_sh <= sinal;
                        r_c        <= 1'b0;
                        r_cnt      <= 2'd0;
                        r_work     <= 4'd0;
                    end
                end
                CALCULA: begin
                    r_work <= w_resultado;
                    r_c    <= w_c_prox;
                    r_cnt  <= r_cnt + 2'd1;
                    if (w_ultimo) begin
                        r_R    <= w_resultado;
                        r_erro <= w_c_prox;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign S    = r_R;
    assign erro = r_erro;

endmodule

// File: tb/tb_reconstrutor_diferenca.sv
// Scoreboard bench for reconstrutor_diferenca: arithmetic reference model feeds a queue, a monitor checks each valido.
module tb_reconstrutor_diferenca;

    logic       clk;
    logic       rst_n;
    logic       carga;
    logic [3:0] A;
    logic       inicio;
    logic       sinal;
    logic [3:0] D;
    logic       pronto;
    logic [3:0] S;
    logic       valido;
    logic       erro;

    int n_cmp = 0;
    int n_err = 0;

    int         m_r = 0;
    logic       m_e = 1'b0;
    logic [4:0] q_exp[$];

    reconstrutor_diferenca dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .carga  (carga),
        .A      (A),
        .inicio (inicio),
        .sinal  (sinal),
        .D      (D),
        .pronto (pronto),
        .S      (S),
        .valido (valido),
        .erro   (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic, wrap flagged when the true result leaves 0..15.
    task automatic model_op(input logic s, input logic [3:0] d);
        int v;
        v   = s ? (m_r - int'(d)) : (m_r + int'(d));
        m_e = (v < 0) || (v > 15);
        m_r = v & 15;
    endtask

    always @(negedge clk) begin
        if (rst_n && valido) begin
            if (q_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valido: got valido=1 expected none (t=%0t)", $time);
            end else begin
                logic [4:0] e;
                e = q_exp.pop_front();
                chk("valido_S", S, e[3:0]);
                chk("valido_erro", erro, e[4]);
            end
        end
    end

    task automatic do_load(input logic [3:0] a);
        @(negedge clk);
        carga = 1'b1;
        A     = a;
        @(posedge clk);
        #1;
        carga = 1'b0;
        m_r   = a;
        m_e   = 1'b0;
        chk("load_S", S, m_r);
        chk("load_erro", erro, 0);
        chk("load_no_valido", valido, 0);
    endtask

    // mode 0: plain op; 1: foreign inicio/carga while busy; 2: reset asserted before E2.
    task automatic do_op(input logic s, input logic [3:0] d, input int mode);
        int kv;
        int kp;
        kv = 0;
        kp = 0;
        @(negedge clk);
        inicio = 1'b1;
        sinal  = s;
        D      = d;
        if (mode != 2) begin
            model_op(s, d);
            q_exp.push_back({m_e, m_r[3:0]});
        end
        @(posedge clk);
        #1;
        chk("pronto_busy", pronto, 0);
        for (int k = 1; k <= 12 && kp == 0; k++) begin
            @(negedge clk);
            if (valido && kv == 0) kv = k;
            if (pronto) kp = k;
            inicio = 1'b0;
            carga  = 1'b0;
            sinal  = 1'($urandom);
            D      = 4'($urandom);
            A      = 4'($urandom);
            if (mode == 1 && k == 1) begin
                inicio = 1'b1;
                D      = 4'd15;
            end
            if (mode == 1 && k == 2) begin
                carga = 1'b1;
                A     = 4'd2;
            end
            if (mode == 2 && k == 2) begin
                rst_n = 1'b0;
                #1;
                m_r = 0;
                m_e = 1'b0;
                chk("abort_S", S, 0);
                chk("abort_pronto", pronto, 1);
                chk("abort_valido", valido, 0);
                chk("abort_erro", erro, 0);
                @(negedge clk);
                rst_n = 1'b1;
                kp    = 99;
            end
        end
        inicio = 1'b0;
        carga  = 1'b0;
        if (mode != 2) begin
            chk("valido_latency", kv, 5);
            chk("pronto_return", kp, 6);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        carga  = 1'b0;
        A      = 4'd0;
        inicio = 1'b0;
        sinal  = 1'b0;
        D      = 4'd0;
        #3;
        chk("rst_S", S, 0);
        chk("rst_erro", erro, 0);
        chk("rst_valido", valido, 0);
        chk("rst_pronto", pronto, 1);
        @(negedge clk);
        rst_n = 1'b1;

        do_load(4'd5);
        do_op(1'b0, 4'd3, 0);
        do_load(4'd5);
        do_op(1'b1, 4'd7, 0);
        do_op(1'b0, 4'd2, 0);
        do_op(1'b1, 4'd0, 0);
        do_load(4'd15);
        do_op(1'b0, 4'd1, 0);
        do_load(4'd9);

        do_load(4'd4);
        do_op(1'b0, 4'd1, 1);
        chk("ignored_reqs_S", S, 5);

        @(negedge clk);
        carga  = 1'b1;
        inicio = 1'b1;
        A      = 4'd6;
        @(posedge clk);
        #1;
        carga  = 1'b0;
        inicio = 1'b0;
        m_r    = 6;
        m_e    = 1'b0;
        chk("carga_wins_S", S, 6);
        chk("carga_wins_pronto", pronto, 1);
        repeat (6) @(negedge clk);
        chk("carga_wins_idle", pronto, 1);

        do_load(4'd10);
        do_op(1'b1, 4'd3, 2);
        repeat (6) @(negedge clk);
        chk("after_abort_S", S, 0);
        do_op(1'b0, 4'd3, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_load(4'($urandom));
            end else begin
                do_op(1'($urandom), 4'($urandom), 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/reconstrutor_diferenca.md
# reconstrutor_diferenca

Sequential inverse of the sign-magnitude difference unit. It holds a 4-bit reconstructed value R and applies incoming (sinal, magnitude) differences to it: R ← R + D when sinal=0, R ← R − D when sinal=1. It sits on the receiving end of a delta-coded 4-bit stream. The arithmetic is bit-serial, LSB first, one bit per clock, so it reuses a single full-adder/subtractor cell behind a start/ready handshake.

## Interface
- No parameters; width fixed at 4 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- carga  input  1  load request; when accepted, R ← A
- A  input  4  value loaded into R on an accepted carga
- inicio  input  1  start request; when accepted, applies one difference
- sinal  input  1  sign of the difference (0 = add, 1 = subtract)
- D  input  4  magnitude of the difference, unsigned
- pronto  output  1  1 while in OCIOSO; carga/inicio are accepted only then
- S  output  4  current reconstructed value R, registered
- valido  output  1  one-cycle pulse; result of the last difference is on S
- erro  output  1  overflow (sinal=0) or underflow (sinal=1) of the last operation

## Operation
- States: OCIOSO, CALCULA, FIM.
- Reset (async, rst_n=0) sets state=OCIOSO, R=0, S=0, erro=0, valido=0, pronto=1, bit counter=0, carry/borrow=0, operand shadows=0.
- OCIOSO:
  - carga=1: R ← A and erro ← 0 on the edge. Stay in OCIOSO; no valido pulse.
  - carga=1 with inicio=1 in the same cycle: carga wins and inicio is dropped.
  - inicio=1 with carga=0: capture D and sinal into shadow registers, clear carry/borrow (c=0), set counter=0, go to CALCULA.
- CALCULA: per edge, process bit i = counter:
  - add: r_i ← R[i] ^ Dsh[i] ^ c; c ← majority(R[i], Dsh[i], c).
  - subtract: r_i ← R[i] ^ Dsh[i] ^ c; c ← (~R[i] & Dsh[i]) | (~(R[i] ^ Dsh[i]) & c) (borrow).
  - Partial result goes to an internal shift/work register. R and S are not modified until completion.
  - After bit 3: R ← work result, erro ← final c, go to FIM.
- FIM: valido=1 for exactly this cycle; next edge goes to OCIOSO.
- carga and inicio outside OCIOSO are ignored; no queuing. A, D and sinal may change freely after acceptance, because the shadows are used.
- Arithmetic is modulo 16: the result wraps and erro flags the wrap.
- sinal=1 with D=0 (negative zero) leaves R unchanged with erro=0, identical to sinal=0, D=0.
- erro holds its value until the next completed operation or accepted carga.

## Timing
- E0 is the edge accepting inicio. Edges E1–E4 process bits 0–3. S and erro update at E4. valido is high between E4 and E5. pronto=1 again after E5.
- Latency inicio→valido: 4 cycles. Throughput: one difference per 6 cycles. Back-to-back start requires inicio held or reasserted in the cycle after E5.
- pronto=0 from E0 through E5 (CALCULA and FIM).
- carga latency: 1 cycle; S reflects A right after the accepting edge.
- S, pronto, valido and erro are all registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- rst_n low at any time, including mid-CALCULA, aborts immediately to reset values. There is no partial update of R.

## Test plan
- Reset: with rst_n=0 asynchronously, S=0, erro=0, valido=0, pronto=1 with no clock edge needed.
- carga A=5, then inicio sinal=0, D=3: valido pulse 5 cycles after inicio, S=8, erro=0, pronto back 1 cycle later.
- carga A=5, then sinal=1, D=7: S=14 (0xE), erro=1. Follow with sinal=0, D=2: S=0, erro=1 (wrap 14+2=16). Then sinal=1, D=0: S=0, erro=0.
- carga A=15, then sinal=0, D=1: S=0, erro=1. Then carga A=9: S=9, erro=0, no valido.
- During CALCULA (R=4, sinal=0, D=1): pulse inicio with D=15, then carga A=2 at E2. Expect result S=5, a single valido, and both requests ignored. Also drive carga=1, inicio=1, A=6 in OCIOSO: S=6 and no operation started.
- Start R=10, sinal=1, D=3, and assert rst_n=0 at E2: S=0, pronto=1, valido never pulses. After release, the next sinal=0, D=3 gives S=3.
